round_timer_ctrl: RTL and testbench

- Game-round sequencer for the programmable level timer (1 ms LFSR timer → 0.1 s counter → level-dependent timeout).
- Each round: clears and arms the timer, enables it, and waits for a player answer or a timeout.
- Scores hits, decrements lives on misses, and raises the difficulty level fed to the timer's curLvl input.
- Sits between the player-input logic and the timer; drives the score/lives display logic.

---
 rtl/round_timer_ctrl.sv | 106 ++++++++++
 tb/tb_round_timer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/round_timer_ctrl.sv
// Game-round sequencer for the level timer: arms/clears the timer each round,
// scores hits, takes lives on misses and raises the level fed to the timer.
module round_timer_ctrl #(
  parameter int MAX_LVL      = 7,
  parameter int START_LIVES  = 3,
  parameter int HITS_PER_LVL = 4,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               answer_valid,
  input  logic               answer_correct,
  input  logic               timeout,
  output logic               timer_en,
  output logic               timer_clr_n,
  output logic [2:0]         cur_lvl,
  output logic               round_active,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, HIT, MISS, OVER} state_t;

  localparam logic [2:0]         LVL_MAX     = 3'(MAX_LVL);
  localparam logic [2:0]         LIVES_INIT  = 3'(START_LIVES);
  localparam logic [3:0]         HIT_LAST    = 4'(HITS_PER_LVL - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [2:0]         lives_reg, lives_next;
  logic [2:0]         lvl_reg, lvl_next;
  logic [3:0]         hit_cnt_reg, hit_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      score_reg   <= '0;
      lives_reg   <= '0;
      lvl_reg     <= '0;
      hit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      score_reg   <= score_next;
      lives_reg   <= lives_next;
      lvl_reg     <= lvl_next;
      hit_cnt_reg <= hit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    score_next   = score_reg;
    lives_next   = lives_reg;
    lvl_next     = lvl_reg;
    hit_cnt_next = hit_cnt_reg;
    unique case (state_reg)
      IDLE, OVER: begin
        if (start) begin
          score_next   = '0;
          lives_next   = LIVES_INIT;
          lvl_next     = 3'd1;
          hit_cnt_next = '0;
          state_next   = ARM;
        end
      end
      ARM: state_next = RUN;
      RUN: begin
        // A submitted answer takes priority over a coincident timeout.
        if (answer_valid && answer_correct) begin
          state_next = HIT;
          if (score_reg != SCORE_MAX) score_next = score_reg + 1'b1;
          if (hit_cnt_reg == HIT_LAST) begin
            hit_cnt_next = '0;
            if (lvl_reg != LVL_MAX) lvl_next = lvl_reg + 3'd1;
          end else begin
            hit_cnt_next = hit_cnt_reg + 4'd1;
          end
        end else if (answer_valid || timeout) begin
          state_next   = MISS;
          hit_cnt_next = '0;
          if (lives_reg != 3'd0) lives_next = lives_reg - 3'd1;
        end
      end
      HIT:  state_next = ARM;
      MISS: state_next = (lives_reg == 3'd0) ? OVER : ARM;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: reset forces IDLE, so these fall back asynchronously.
  assign timer_en     = (state_reg == RUN);
  assign round_active = (state_reg == RUN);
  assign timer_clr_n  = (state_reg != ARM);
  assign hit_pulse    = (state_reg == HIT);
  assign miss_pulse   = (state_reg == MISS);
  assign game_over    = (state_reg == OVER);
  assign score        = score_reg;
  assign lives        = lives_reg;
  assign cur_lvl      = lvl_reg;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Randomized round-level bench for round_timer_ctrl with a game-rules scoreboard.
module tb_round_timer_ctrl;
  localparam int SCORE_W   = 4;
  localparam int SCORE_TOP = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, answer_valid = 1'b0, answer_correct = 1'b0, timeout = 1'b0;
  logic timer_en, timer_clr_n, round_active, hit_pulse, miss_pulse, game_over;
  logic [2:0] cur_lvl, lives;
  logic [SCORE_W-1:0] score;

  int n_vec = 0;
  int n_bad = 0;

  // game-level reference state
  int m_score, m_lives, m_lvl, m_streak;

  always #5 clk = ~clk;

  round_timer_ctrl #(.MAX_LVL(7), .START_LIVES(3), .HITS_PER_LVL(4), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .answer_valid(answer_valid),
    .answer_correct(answer_correct), .timeout(timeout), .timer_en(timer_en),
    .timer_clr_n(timer_clr_n), .cur_lvl(cur_lvl), .round_active(round_active),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .lives(lives),
    .game_over(game_over)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".lives"}, int'(lives), m_lives);
    chk({tag, ".lvl"},   int'(cur_lvl), m_lvl);
  endtask

  task automatic clear_in();
    start = 0; answer_valid = 0; answer_correct = 0; timeout = 0;
  endtask

  // Pulses that must have no effect in the current (non-RUN) state.
  task automatic stray(input bit allow_start);
    answer_valid   = 1'($urandom_range(0, 1));
    answer_correct = 1'($urandom_range(0, 1));
    timeout        = 1'($urandom_range(0, 1));
    start          = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic model_reset();
    m_score = 0; m_lives = 0; m_lvl = 0; m_streak = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".timer_en"}, int'(timer_en), 0);
    chk({tag, ".clr_n"}, int'(timer_clr_n), 1);
    chk({tag, ".active"}, int'(round_active), 0);
    chk({tag, ".hit"}, int'(hit_pulse), 0);
    chk({tag, ".miss"}, int'(miss_pulse), 0);
    chk({tag, ".over"}, int'(game_over), 0);
    chk_counts(tag);
  endtask

  // From IDLE/OVER at a negedge: pulse start, see ARM then RUN.
  task automatic do_start();
    clear_in();
    start = 1;
    @(negedge clk);
    clear_in();
    m_score = 0; m_lives = 3; m_lvl = 1; m_streak = 0;
    chk("arm.clr_n", int'(timer_clr_n), 0);
    chk("arm.en", int'(timer_en), 0);
    chk_counts("arm");
    stray(1'b1);
    @(negedge clk);
    clear_in();
    chk("run.active", int'(round_active), 1);
    chk("run.en", int'(timer_en), 1);
    chk("run.clr_n", int'(timer_clr_n), 1);
    chk_counts("run");
  endtask

  // act: 0 correct, 1 wrong, 2 timeout, 3 correct+timeout, 4 wrong+timeout
  task automatic play_round(input int act, input int dly, output bit over);
    bit is_hit;
    for (int i = 0; i < dly; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 0;
      chk("wait.active", int'(round_active), 1);
      chk("wait.lvl", int'(cur_lvl), m_lvl);
    end
    answer_valid   = (act != 2);
    answer_correct = (act == 0 || act == 3);
    timeout        = (act >= 2);
    is_hit = (act == 0 || act == 3);
    @(negedge clk);
    clear_in();
    if (is_hit) begin
      m_score = (m_score < SCORE_TOP) ? m_score + 1 : SCORE_TOP;
      m_streak++;
      if (m_streak == 4) begin
        m_streak = 0;
        if (m_lvl < 7) m_lvl++;
      end
    end else begin
      m_streak = 0;
      if (m_lives > 0) m_lives--;
    end
    $display("round act=%0d dly=%0d -> score=%0d lives=%0d lvl=%0d", act, dly, score, lives, cur_lvl);
    chk("res.hit", int'(hit_pulse), int'(is_hit));
    chk("res.miss", int'(miss_pulse), int'(!is_hit));
    chk("res.en", int'(timer_en), 0);
    chk_counts("res");
    stray(1'b1);
    @(negedge clk);
    clear_in();
    over = (m_lives == 0);
    if (over) begin
      chk("over.flag", int'(game_over), 1);
      chk("over.en", int'(timer_en), 0);
      chk_counts("over");
    end else begin
      chk("rearm.clr_n", int'(timer_clr_n), 0);
      chk("rearm.en", int'(timer_en), 0);
      chk_counts("rearm");
      stray(1'b1);
      @(negedge clk);
      clear_in();
      chk("rerun.en", int'(timer_en), 1);
      chk("rerun.active", int'(round_active), 1);
      chk_counts("rerun");
    end
  endtask

  task automatic idle_in_over(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      stray(1'b0);
      @(negedge clk);
      clear_in();
      chk("hold.over", int'(game_over), 1);
      chk("hold.en", int'(timer_en), 0);
      chk_counts("hold");
    end
  endtask

  initial begin
    bit over;
    int act;
    model_reset();
    clear_in();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1;
    stray(1'b0);
    @(negedge clk);
    clear_in();
    check_reset_outputs("idle");

    // first game: 4 hits then 3 timeouts
    do_start();
    for (int i = 0; i < 4; i++) play_round(0, $urandom_range(0, 3), over);
    chk("lvl_up", int'(cur_lvl), 2);
    for (int i = 0; i < 3; i++) play_round(2, $urandom_range(0, 3), over);
    chk("game_end", int'(over), 1);
    idle_in_over(3);

    // coincident answer/timeout, then a long hit run to both saturations
    do_start();
    play_round(3, 0, over);
    for (int i = 0; i < 27; i++) play_round(0, $urandom_range(0, 2), over);
    chk("sat.lvl", int'(cur_lvl), 7);
    chk("sat.score", int'(score), SCORE_TOP);
    for (int i = 0; i < 3; i++) play_round(4, $urandom_range(0, 2), over);
    idle_in_over(2);

    // random games
    for (int g = 0; g < 6; g++) begin
      do_start();
      over = 0;
      for (int r = 0; r < 40 && !over; r++) begin
        act = $urandom_range(0, 9);
        act = (act <= 5) ? 0 : act - 5;
        play_round(act, $urandom_range(0, 4), over);
      end
      if (over) idle_in_over(1);
    end

    // asynchronous reset in the middle of a round
    do_start();
    play_round(0, 1, over);
    #2 rst = 0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("post_rst");
    do_start();
    play_round(1, 1, over);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
